data_mem_ctrl: RTL and testbench

- Parametrised data-memory block for the MIPS core, sitting between the core's load/store port and word-organised on-chip storage.
- Adds what the plain single-cycle data RAM lacks:
  - req/ready handshake with configurable wait states, so the core can stall;
  - MIPS byte/halfword/word stores with byte lanes;
  - sign- or zero-extended loads;
  - alignment and range error flagging;
  - access counters.

---
 rtl/data_mem_if.sv | 27 ++
 rtl/data_mem_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Load/store port between the MIPS core (master) and the data-memory controller (slave).
interface data_mem_if #(
    parameter int CNT_W = 32
);
    logic             req;
    logic             we;
    logic [1:0]       size;
    logic             uns;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;
    logic             ready;
    logic             busy;
    logic             addr_err;
    logic [CNT_W-1:0] rd_cnt;
    logic [CNT_W-1:0] wr_cnt;

    modport master (
        output req, we, size, uns, addr, wdata,
        input  rdata, ready, busy, addr_err, rd_cnt, wr_cnt
    );

    modport slave (
        input  req, we, size, uns, addr, wdata,
        output rdata, ready, busy, addr_err, rd_cnt, wr_cnt
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory for the MIPS core: req/ready handshake with wait states, byte lanes,
// extended loads, alignment/range error flagging and access counters.
//   state  | meaning
//   S_IDLE | waiting for req; request is sampled here only
//   S_WAIT | counting WAIT_CYCLES wait states
//   S_RESP | ready pulse; rdata/addr_err valid
module data_mem_ctrl #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 32
) (
    input logic        clk_i,
    input logic        rst_ni,
    data_mem_if.slave  bus_if
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e           state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             we_q, uns_q;
    logic [1:0]       size_q;
    logic [31:0]      addr_q, wdata_q;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] rd_cnt_q, wr_cnt_q;

    logic             accept, enter_resp;
    logic             cur_we, cur_uns, cur_err;
    logic [1:0]       cur_size;
    logic [31:0]      cur_addr, cur_wdata;
    logic [IDX_W-1:0] cur_idx;
    logic [3:0]       lane_be;
    logic [31:0]      lane_data, mem_word, ld_val;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;

    logic [31:0]      mem_q [DEPTH];

    // With no wait states the access commits on its acceptance edge, so in IDLE
    // the commit path works from the live request instead of the latched copy.
    always_comb begin
        cur_we    = we_q;
        cur_size  = size_q;
        cur_uns   = uns_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            cur_we    = bus_if.we;
            cur_size  = bus_if.size;
            cur_uns   = bus_if.uns;
            cur_addr  = bus_if.addr;
            cur_wdata = bus_if.wdata;
        end
    end

    assign cur_idx = cur_addr[IDX_W+1:2];
    assign cur_err = (cur_size == 2'b11)
                   | ((cur_size == 2'b01) & cur_addr[0])
                   | ((cur_size == 2'b10) & (|cur_addr[1:0]))
                   | (|cur_addr[31:IDX_W+2]);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        accept     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_if.req) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = S_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

    always_comb begin
        lane_be   = 4'b1111;
        lane_data = cur_wdata;
        case (cur_size)
            2'b00: begin
                lane_be   = 4'b0001 << cur_addr[1:0];
                lane_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                lane_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign mem_word = mem_q[cur_idx];

    always_comb begin
        ld_byte = mem_word[{cur_addr[1:0], 3'b000} +: 8];
        ld_half = cur_addr[1] ? mem_word[31:16] : mem_word[15:0];
        ld_val  = mem_word;
        case (cur_size)
            2'b00:   ld_val = {{24{ld_byte[7] & ~cur_uns}}, ld_byte};
            2'b01:   ld_val = {{16{ld_half[15] & ~cur_uns}}, ld_half};
            default: ld_val = mem_word;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (enter_resp) begin
            if (cur_err) begin
                rdata_d = 32'd0;
            end else if (!cur_we) begin
                rdata_d = ld_val;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            we_q    <= bus_if.we;
            size_q  <= bus_if.size;
            uns_q   <= bus_if.uns;
            addr_q  <= bus_if.addr;
            wdata_q <= bus_if.wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if ((state_q == S_RESP) && !cur_err) begin
            if (cur_we) begin
                wr_cnt_q <= wr_cnt_q + CNT_W'(1);
            end else begin
                rd_cnt_q <= rd_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (enter_resp && cur_we && !cur_err) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_be[k]) begin
                    mem_q[cur_idx][8*k +: 8] <= lane_data[8*k +: 8];
                end
            end
        end
    end

    assign bus_if.rdata    = rdata_q;
    assign bus_if.ready    = (state_q == S_RESP);
    assign bus_if.busy     = (state_q != S_IDLE);
    assign bus_if.addr_err = (state_q == S_RESP) && cur_err;
    assign bus_if.rd_cnt   = rd_cnt_q;
    assign bus_if.wr_cnt   = wr_cnt_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: directed vector table, hand-written multi-cycle sequences,
// and random accesses checked against a byte-addressed reference model.
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;
    localparam int WA    = 2;
    localparam int WB    = 0;

    logic clk;
    logic rst_a_n, rst_b_n;

    data_mem_if #(.CNT_W(32)) bus_a ();
    data_mem_if #(.CNT_W(32)) bus_b ();

    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WA), .CNT_W(32)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_a_n), .bus_if(bus_a.slave)
    );
    data_mem_ctrl #(.DEPTH(DEPTH), .WAIT_CYCLES(WB), .CNT_W(32)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_b_n), .bus_if(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  m_mem  [2][4096];
    logic [31:0] m_last [2];
    int unsigned m_rd   [2];
    int unsigned m_wr   [2];

    typedef struct {
        bit          we;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit req, input bit we, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (!sel) begin
            bus_a.req = req; bus_a.we = we; bus_a.size = size;
            bus_a.uns = uns; bus_a.addr = addr; bus_a.wdata = wdata;
        end else begin
            bus_b.req = req; bus_b.we = we; bus_b.size = size;
            bus_b.uns = uns; bus_b.addr = addr; bus_b.wdata = wdata;
        end
    endtask

    function automatic logic o_ready(input bit sel);
        return sel ? bus_b.ready : bus_a.ready;
    endfunction
    function automatic logic o_busy(input bit sel);
        return sel ? bus_b.busy : bus_a.busy;
    endfunction
    function automatic logic o_err(input bit sel);
        return sel ? bus_b.addr_err : bus_a.addr_err;
    endfunction
    function automatic logic [31:0] o_rdata(input bit sel);
        return sel ? bus_b.rdata : bus_a.rdata;
    endfunction
    function automatic logic [31:0] o_rd_cnt(input bit sel);
        return sel ? bus_b.rd_cnt : bus_a.rd_cnt;
    endfunction
    function automatic logic [31:0] o_wr_cnt(input bit sel);
        return sel ? bus_b.wr_cnt : bus_a.wr_cnt;
    endfunction

    // Reference: byte-addressed memory, errors from plain arithmetic on the address.
    function automatic void model_apply(input bit sel, input bit we, input logic [1:0] size,
                                        input bit uns, input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        output logic [31:0] exp_rd, output bit exp_err);
        int unsigned au;
        int unsigned nb;
        logic [63:0] val;
        au = addr;
        nb = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        exp_err = (size == 2'b11) || ((au % nb) != 0) || ((au / 4) >= DEPTH);
        if (exp_err) begin
            m_last[sel] = 32'd0;
        end else if (we) begin
            for (int b = 0; b < int'(nb); b++) m_mem[sel][au + b] = wdata[8*b +: 8];
            m_wr[sel]++;
        end else begin
            val = 64'd0;
            for (int b = 0; b < int'(nb); b++) val = val | (64'(m_mem[sel][au + b]) << (8*b));
            if (!uns && val[8*nb-1]) val = val | (~64'd0 << (8*nb));
            m_last[sel] = val[31:0];
            m_rd[sel]++;
        end
        exp_rd = m_last[sel];
    endfunction

    // Starts and ends on a falling edge with the DUT idle.
    task automatic access(input bit sel, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got_rd, output bit got_err,
                          output logic [31:0] exp_rd, output bit exp_err);
        int n, busy_n, waitc;
        bit seen;
        waitc  = sel ? WB : WA;
        seen   = 1'b0;
        busy_n = 0;
        got_rd = 32'd0;
        got_err = 1'b0;
        drive(sel, 1'b1, we, size, uns, addr, wdata);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        n = 1;
        while (n <= 20) begin
            if (o_busy(sel)) busy_n++;
            if (o_ready(sel)) begin
                seen    = 1'b1;
                got_rd  = o_rdata(sel);
                got_err = o_err(sel);
                break;
            end
            @(negedge clk);
            n++;
        end
        if (!seen) $display("FAIL ready_timeout got=none exp=ready");
        chk("latency", n, waitc + 1);
        chk("busy_cycles", busy_n, waitc + 1);
        model_apply(sel, we, size, uns, addr, wdata, exp_rd, exp_err);
        @(negedge clk);
        chk("idle_after", {o_ready(sel), o_busy(sel), o_err(sel)}, 32'd0);
        chk("rd_cnt", o_rd_cnt(sel), m_rd[sel]);
        chk("wr_cnt", o_wr_cnt(sel), m_wr[sel]);
    endtask

    logic [31:0] got_rd, exp_rd;
    bit          got_err, exp_err;
    logic [31:0] b2b_exp [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4096; i++) m_mem[s][i] = 8'h00;
            m_last[s] = 32'd0; m_rd[s] = 0; m_wr[s] = 0;
        end
        drive(0, 0, 0, 2'b00, 0, 32'd0, 32'd0);
        drive(1, 0, 0, 2'b00, 0, 32'd0, 32'd0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        #1;
        rst_a_n = 1'b0; rst_b_n = 1'b0;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_ctrl_a", {bus_a.ready, bus_a.busy, bus_a.addr_err}, 32'd0);
            chk("rst_rdata_a", bus_a.rdata, 32'd0);
            chk("rst_cnt_a", bus_a.rd_cnt | bus_a.wr_cnt, 32'd0);
            chk("rst_ctrl_b", {bus_b.ready, bus_b.busy, bus_b.addr_err}, 32'd0);
        end
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        @(negedge clk);

        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h10,   32'h12345678, 32'h00000000, 1'b0});
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h20,   32'h11223344, 32'h00000000, 1'b0});
        vt.push_back('{1'b1, 2'b00, 1'b0, 32'h21,   32'h000000AA, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 2'b00, 1'b0, 32'h21,   32'h0,        32'hFFFFFFAA, 1'b0});
        vt.push_back('{1'b0, 2'b00, 1'b1, 32'h21,   32'h0,        32'h000000AA, 1'b0});
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h20,   32'h0,        32'h1122AA44, 1'b0});
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h30,   32'h55667788, 32'h1122AA44, 1'b0});
        vt.push_back('{1'b1, 2'b01, 1'b0, 32'h32,   32'h00008001, 32'h1122AA44, 1'b0});
        vt.push_back('{1'b0, 2'b01, 1'b0, 32'h32,   32'h0,        32'hFFFF8001, 1'b0});
        vt.push_back('{1'b0, 2'b01, 1'b1, 32'h32,   32'h0,        32'h00008001, 1'b0});
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h30,   32'h0,        32'h80017788, 1'b0});
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h00,   32'hCAFEF00D, 32'h80017788, 1'b0});
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h02,   32'h0,        32'h00000000, 1'b1});
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h1000, 32'h00000BAD, 32'h00000000, 1'b1});
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h00,   32'h0,        32'hCAFEF00D, 1'b0});
        vt.push_back('{1'b0, 2'b11, 1'b0, 32'h04,   32'h0,        32'h00000000, 1'b1});
        vt.push_back('{1'b0, 2'b10, 1'b0, 32'h00,   32'h0,        32'hCAFEF00D, 1'b0});
        vt.push_back('{1'b1, 2'b01, 1'b0, 32'h33,   32'h00001234, 32'h00000000, 1'b1});
        vt.push_back('{1'b1, 2'b00, 1'b0, 32'hFFF,  32'h0000005A, 32'h00000000, 1'b0});
        vt.push_back('{1'b0, 2'b00, 1'b1, 32'hFFF,  32'h0,        32'h0000005A, 1'b0});
        vt.push_back('{1'b0, 2'b00, 1'b0, 32'h1000, 32'h0,        32'h00000000, 1'b1});
        vt.push_back('{1'b0, 2'b01, 1'b0, 32'h30,   32'h0,        32'h00007788, 1'b0});
        vt.push_back('{1'b0, 2'b00, 1'b0, 32'h22,   32'h0,        32'h00000022, 1'b0});
        vt.push_back('{1'b1, 2'b10, 1'b0, 32'h03,   32'h01020304, 32'h00000000, 1'b1});

        foreach (vt[i]) begin
            access(0, vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
                   got_rd, got_err, exp_rd, exp_err);
            chk($sformatf("vec%0d_rdata", i), got_rd, vt[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(got_err), 32'(vt[i].exp_err));
        end

        // Reset while the store sits in its wait states: it must never land.
        access(0, 1, 2'b10, 0, 32'h40, 32'h0, got_rd, got_err, exp_rd, exp_err);
        drive(0, 1, 1, 2'b10, 0, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 0, 32'd0, 32'd0);
        chk("mid_busy_before_rst", 32'(bus_a.busy), 32'd1);
        rst_a_n = 1'b0;
        m_rd[0] = 0; m_wr[0] = 0; m_last[0] = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_ctrl", {bus_a.ready, bus_a.busy, bus_a.addr_err}, 32'd0);
        end
        chk("mid_rst_cnt", bus_a.wr_cnt, 32'd0);
        rst_a_n = 1'b1;
        @(negedge clk);
        access(0, 0, 2'b10, 0, 32'h40, 32'h0, got_rd, got_err, exp_rd, exp_err);
        chk("mid_rst_lw", got_rd, 32'h00000000);
        chk("mid_rst_lw_model", got_rd, exp_rd);

        // Back-to-back with req held high; odd-cycle requests land on RESP and are dropped.
        access(1, 1, 2'b10, 0, 32'h60, 32'h0, got_rd, got_err, exp_rd, exp_err);
        for (int i = 0; i <= 10; i++) begin
            int k;
            if (i > 0) begin
                chk($sformatf("b2b_ready%0d", i), 32'(bus_b.ready), 32'(i % 2));
                if (i % 2 == 1) chk($sformatf("b2b_rdata%0d", i), bus_b.rdata, b2b_exp[i-1]);
            end
            if (i == 10) begin
                drive(1, 0, 0, 2'b00, 0, 32'd0, 32'd0);
            end else if (i % 2 == 0) begin
                k = i / 2;
                drive(1, 1, (k % 2 == 0), 2'b10, 0, 32'h50 + 32'(4 * (k / 2)), 32'hA5000000 + 32'(k));
                model_apply(1, (k % 2 == 0), 2'b10, 0, 32'h50 + 32'(4 * (k / 2)),
                            32'hA5000000 + 32'(k), b2b_exp[i], exp_err);
            end else begin
                drive(1, 1, 1, 2'b10, 0, 32'h60, 32'hBAD00000 + 32'(i));
            end
            @(negedge clk);
        end
        chk("b2b_wr_cnt", bus_b.wr_cnt, 32'd4);
        chk("b2b_rd_cnt", bus_b.rd_cnt, 32'd2);
        access(1, 0, 2'b10, 0, 32'h60, 32'h0, got_rd, got_err, exp_rd, exp_err);
        chk("b2b_ignored_store", got_rd, 32'h00000000);

        // Random accesses on both instances against the reference model.
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < 16; w++) begin
                access(s[0], 1, 2'b10, 0, 32'(4 * w), $urandom, got_rd, got_err, exp_rd, exp_err);
                chk("fill_err", 32'(got_err), 32'(exp_err));
            end
            for (int t = 0; t < 120; t++) begin
                bit          r_we, r_uns;
                logic [1:0]  r_size;
                logic [31:0] r_addr;
                int          r;
                r_we   = 1'($urandom_range(0, 1));
                r_uns  = 1'($urandom_range(0, 1));
                r      = $urandom_range(0, 9);
                r_size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
                if ($urandom_range(0, 9) == 0) begin
                    r_addr = $urandom_range(0, 1) ? 32'h1000 + 32'($urandom_range(0, 255))
                                                  : ($urandom | 32'h80000000);
                end else begin
                    r_addr = 32'($urandom_range(0, 63));
                end
                access(s[0], r_we, r_size, r_uns, r_addr, $urandom, got_rd, got_err, exp_rd, exp_err);
                chk($sformatf("rnd%0d_%0d_rdata", s, t), got_rd, exp_rd);
                chk($sformatf("rnd%0d_%0d_err", s, t), 32'(got_err), 32'(exp_err));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
